// File: rtl/coproc_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module : coproc_issue_queue_if
// Brief  : Issue, commit and execute channels of the coprocessor issue queue.
// Rev    : 1.0  initial release
// ============================================================================
interface coproc_issue_queue_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
);
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [31:0]           issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [XLEN-1:0]       issue_rs0_i;
  logic [XLEN-1:0]       issue_rs1_i;
  logic                  issue_accept_o;
  logic                  issue_writeback_o;
  logic                  issue_loadstore_o;

  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;

  logic                  exe_valid_o;
  logic                  exe_ready_i;
  logic [31:0]           exe_instr_o;
  logic [X_ID_WIDTH-1:0] exe_id_o;
  logic [XLEN-1:0]       exe_rs0_o;
  logic [XLEN-1:0]       exe_rs1_o;

  logic [c_OCC_W-1:0]    occupancy_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  exe_valid_o, exe_instr_o, exe_id_o, exe_rs0_o, exe_rs1_o,
    output exe_ready_i,
    input  occupancy_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output exe_valid_o, exe_instr_o, exe_id_o, exe_rs0_o, exe_rs1_o,
    input  exe_ready_i,
    output occupancy_o
  );
endinterface
`default_nettype wire

// File: rtl/coproc_issue_queue.sv
`default_nettype none
// ============================================================================
// Module : coproc_issue_queue
// Brief  : In-order CV-X-IF issue queue; buffers accepted instructions until
//          commit/kill, releases committed ones in order to the execute stage.
// Config : COPROC_IQ_ID_CHECK_EN - stall issue while issue_id_i is in flight.
// Rev    : 1.0  initial release
// ============================================================================
module coproc_issue_queue #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  coproc_issue_queue_if.slave   xif
);
  localparam int              c_PW      = $clog2(DEPTH);
  localparam int              c_CW      = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [6:0]      c_OP_RMLD = 7'h08;
  localparam logic [6:0]      c_OP_RMST = 7'h09;
  localparam logic [6:0]      c_OP_TEST = 7'h0A;

  logic [31:0]           r_instr [DEPTH];
  logic [X_ID_WIDTH-1:0] r_id    [DEPTH];
  logic [XLEN-1:0]       r_rs0   [DEPTH];
  logic [XLEN-1:0]       r_rs1   [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH-1:0]      r_cmt;
  logic [DEPTH-1:0]      r_kill;
  logic [c_PW-1:0]       r_wptr;
  logic [c_PW-1:0]       r_rptr;
  logic [c_CW-1:0]       r_count;

  logic            w_accept, w_wb, w_ls;
  logic            w_ready, w_push, w_pop, w_push_cm;
  logic            w_head_vld, w_exe_valid, w_head_drop;
  logic            w_cm_hit;
  logic [c_PW-1:0] w_cm_idx, w_scan;

  always_comb begin
    w_accept = 1'b0;
    w_wb     = 1'b0;
    w_ls     = 1'b0;
    case (xif.issue_instr_i[6:0])
      c_OP_RMLD: begin w_accept = 1'b1; w_wb = 1'b1; w_ls = 1'b1; end
      c_OP_RMST: begin w_accept = 1'b1; w_ls = 1'b1; end
      c_OP_TEST: begin w_accept = 1'b1; w_wb = 1'b1; end
      default:   ;
    endcase
  end

`ifdef COPROC_IQ_ID_CHECK_EN
  logic w_id_busy;
  always_comb begin
    w_id_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_id[i] == xif.issue_id_i)) w_id_busy = 1'b1;
    end
  end
  assign w_ready = (r_count != c_FULL) && !w_id_busy;
`else
  assign w_ready = (r_count != c_FULL);
`endif

  // Scan from the head so the first hit is the oldest matching entry.
  always_comb begin
    w_cm_hit = 1'b0;
    w_cm_idx = '0;
    w_scan   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan = r_rptr + c_PW'(k);
      if (!w_cm_hit && xif.commit_valid_i && r_vld[w_scan] && !r_cmt[w_scan] &&
          (r_id[w_scan] == xif.commit_id_i)) begin
        w_cm_hit = 1'b1;
        w_cm_idx = w_scan;
      end
    end
  end

  assign w_push      = xif.issue_valid_i && w_ready && w_accept;
  // The entry being pushed is younger than everything stored, so it only
  // takes the commit when no stored entry matched.
  assign w_push_cm   = w_push && xif.commit_valid_i && !w_cm_hit &&
                       (xif.issue_id_i == xif.commit_id_i);
  assign w_head_vld  = r_vld[r_rptr];
  assign w_exe_valid = w_head_vld && r_cmt[r_rptr] && !r_kill[r_rptr];
  assign w_head_drop = w_head_vld && r_cmt[r_rptr] && r_kill[r_rptr];
  assign w_pop       = (w_exe_valid && xif.exe_ready_i) || w_head_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_id[i]    <= '0;
        r_rs0[i]   <= '0;
        r_rs1[i]   <= '0;
      end
      r_vld   <= '0;
      r_cmt   <= '0;
      r_kill  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_cm_hit) begin
        r_cmt[w_cm_idx]  <= 1'b1;
        r_kill[w_cm_idx] <= xif.commit_kill_i;
      end
      if (w_pop) begin
        r_vld[r_rptr]  <= 1'b0;
        r_cmt[r_rptr]  <= 1'b0;
        r_kill[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + c_PW'(1);
      end
      if (w_push) begin
        r_instr[r_wptr] <= xif.issue_instr_i;
        r_id[r_wptr]    <= xif.issue_id_i;
        r_rs0[r_wptr]   <= xif.issue_rs0_i;
        r_rs1[r_wptr]   <= xif.issue_rs1_i;
        r_vld[r_wptr]   <= 1'b1;
        r_cmt[r_wptr]   <= w_push_cm;
        r_kill[r_wptr]  <= w_push_cm && xif.commit_kill_i;
        r_wptr          <= r_wptr + c_PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  assign xif.issue_ready_o     = w_ready;
  assign xif.issue_accept_o    = w_accept;
  assign xif.issue_writeback_o = w_wb;
  assign xif.issue_loadstore_o = w_ls;
  assign xif.exe_valid_o       = w_exe_valid;
  assign xif.exe_instr_o       = r_instr[r_rptr];
  assign xif.exe_id_o          = r_id[r_rptr];
  assign xif.exe_rs0_o         = r_rs0[r_rptr];
  assign xif.exe_rs1_o         = r_rs1[r_rptr];
  assign xif.occupancy_o       = r_count;
endmodule
`default_nettype wire
